// File: rtl/config_loader_pkg.sv
// config_loader_pkg: state encodings, default sizes and sizing helpers shared by config_loader.
package config_loader_pkg;

   localparam int unsigned DEF_CHAIN_LENGTH = 64;
   localparam int unsigned DEF_WORD_WIDTH   = 32;

   typedef logic [2:0] state_t;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   function automatic int unsigned num_words(input int unsigned chain_length,
                                             input int unsigned word_width);
      return (chain_length + word_width - 1) / word_width;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/config_loader_if.sv
// config_loader_if: valid/ready bitstream word port between the source (master) and loader (slave).
interface config_loader_if #(
   parameter int unsigned WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_loader_serializer.sv
// config_serializer: holds one bitstream word and presents it MSB-first, flagging its last bit.
module config_serializer
   import config_loader_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [WORD_WIDTH-1:0] word,
   output logic                  msb,
   output logic                  last_bit
);
   localparam int unsigned IDX_W = cnt_width(WORD_WIDTH);

   logic [WORD_WIDTH-1:0] shreg;
   logic [IDX_W-1:0]      idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         idx   <= '0;
      end else if (load) begin
         shreg <= word;
         idx   <= '0;
      end else if (shift) begin
         shreg <= shreg << 1;
         idx   <= idx + 1'b1;
      end
   end

   assign msb      = shreg[WORD_WIDTH-1];
   assign last_bit = (idx == IDX_W'(WORD_WIDTH - 1));
endmodule

// File: rtl/config_loader.sv
// config_loader: drives a configuration shift chain MSB-first from a valid/ready word stream.
// Build option CONFIG_CRC_EN adds a trailing XOR check word; mismatch raises error.
module config_loader
   import config_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LENGTH = DEF_CHAIN_LENGTH,
   parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   config_loader_if.slave bus,
   output logic           shift_enable,
   output logic           shift_data,
   output logic           busy,
   output logic           done,
   output logic           error
);
   localparam int unsigned BC_W = cnt_width(CHAIN_LENGTH);

   state_t          state;
   logic [BC_W-1:0] bit_cnt;
   logic            shifting;
   logic            word_load;
   logic            chain_end;
   logic            ser_msb;
   logic            ser_last;

   assign shifting  = (state == SHIFT);
   assign word_load = bus.in_valid && (state == LOAD);
   assign chain_end = (bit_cnt == BC_W'(CHAIN_LENGTH - 1));

`ifdef CONFIG_CRC_EN
   assign bus.in_ready = (state == LOAD) || (state == CHECK);
`else
   assign bus.in_ready = (state == LOAD);
`endif

   // Chain end takes priority so a partially used last word is abandoned mid-word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= LOAD;
                  bit_cnt <= '0;
               end
            end
            LOAD: begin
               if (bus.in_valid) state <= SHIFT;
            end
            SHIFT: begin
               bit_cnt <= bit_cnt + 1'b1;
               if (chain_end) begin
`ifdef CONFIG_CRC_EN
                  state <= CHECK;
`else
                  state <= DONE;
`endif
               end else if (ser_last) begin
                  state <= LOAD;
               end
            end
`ifdef CONFIG_CRC_EN
            CHECK: begin
               if (bus.in_valid) state <= DONE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CONFIG_CRC_EN
   logic [WORD_WIDTH-1:0] crc_acc;
   logic                  error_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_acc <= '0;
         error_q <= 1'b0;
      end else if (start && (state == IDLE || state == DONE)) begin
         crc_acc <= '0;
         error_q <= 1'b0;
      end else if (word_load) begin
         crc_acc <= crc_acc ^ bus.in_data;
      end else if (bus.in_valid && state == CHECK) begin
         error_q <= (bus.in_data != crc_acc);
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   config_serializer #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (word_load),
      .shift    (shifting),
      .word     (bus.in_data),
      .msb      (ser_msb),
      .last_bit (ser_last)
   );

   assign shift_enable = shifting;
   assign shift_data   = shifting && ser_msb;
   assign busy         = (state == LOAD) || (state == SHIFT) || (state == CHECK);
   assign done         = (state == DONE);
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed checks of config_loader driving a modelled shift chain (64- and 40-bit).
// With CONFIG_CRC_EN defined the loads append the XOR check word and the error path is exercised.
module tb_config_loader;

`ifdef CONFIG_CRC_EN
   localparam int CRC_CYC = 1;
`else
   localparam int CRC_CYC = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start64 = 1'b0;
   logic start40 = 1'b0;
   logic se64, sd64, busy64, done64, err64;
   logic se40, sd40, busy40, done40, err40;

   logic [63:0] chain64;
   logic [39:0] chain40;
   int se_cnt64, busy_cnt64, se_cnt40, busy_cnt40;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   config_loader_if #(.WORD_WIDTH(32)) bus64 ();
   config_loader_if #(.WORD_WIDTH(32)) bus40 ();

   config_loader #(.CHAIN_LENGTH(64), .WORD_WIDTH(32)) dut64 (
      .clk(clk), .rst(rst), .start(start64), .bus(bus64),
      .shift_enable(se64), .shift_data(sd64), .busy(busy64), .done(done64), .error(err64)
   );

   config_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(32)) dut40 (
      .clk(clk), .rst(rst), .start(start40), .bus(bus40),
      .shift_enable(se40), .shift_data(sd40), .busy(busy40), .done(done40), .error(err40)
   );

   // Shift chain models plus shift/busy cycle counters, restarted by an accepted start.
   always @(posedge clk) begin
      if (rst) begin
         chain64 <= '0;
         chain40 <= '0;
      end else begin
         if (se64) chain64 <= {chain64[62:0], sd64};
         if (se40) chain40 <= {chain40[38:0], sd40};
      end
      if (rst || (start64 && !busy64)) begin
         se_cnt64 <= 0; busy_cnt64 <= 0;
      end else begin
         if (se64) se_cnt64 <= se_cnt64 + 1;
         if (busy64) busy_cnt64 <= busy_cnt64 + 1;
      end
      if (rst || (start40 && !busy40)) begin
         se_cnt40 <= 0; busy_cnt40 <= 0;
      end else begin
         if (se40) se_cnt40 <= se_cnt40 + 1;
         if (busy40) busy_cnt40 <= busy_cnt40 + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input bit sel40);
      @(negedge clk);
      if (sel40) start40 = 1'b1; else start64 = 1'b1;
      @(posedge clk);
      #1;
      start40 = 1'b0;
      start64 = 1'b0;
   endtask

   task automatic send_word(input bit sel40, input logic [31:0] w, input int gap);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sel40 ? bus40.in_ready : bus64.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("ready_timeout", 64'd0, 64'd1);
      end else begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("stall_shift_enable", sel40 ? se40 : se64, 64'd0);
         end
         if (sel40) begin bus40.in_data = w; bus40.in_valid = 1'b1; end
         else       begin bus64.in_data = w; bus64.in_valid = 1'b1; end
         @(posedge clk);
         #1;
         bus40.in_valid = 1'b0;
         bus64.in_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input bit sel40);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sel40 ? done40 : done64) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_load(input bit sel40, input logic [31:0] w0, input logic [31:0] w1,
                           input int g0, input int g1, input logic [31:0] chk);
      pulse_start(sel40);
      send_word(sel40, w0, g0);
      send_word(sel40, w1, g1);
`ifdef CONFIG_CRC_EN
      send_word(sel40, chk, 0);
`else
      if (chk != 32'h0) begin end
`endif
      wait_done(sel40);
   endtask

   initial begin
      int g0, g1;
      bus64.in_data = '0; bus64.in_valid = 1'b0;
      bus40.in_data = '0; bus40.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", bus64.in_ready, 64'd0);
      check("rst_shift_enable", se64, 64'd0);
      check("rst_shift_data", sd64, 64'd0);
      check("rst_busy", busy64, 64'd0);
      check("rst_done", done64, 64'd0);
      check("rst_error", err64, 64'd0);

      // Test 1: full 64-bit load, back-to-back words
      run_load(1'b0, 32'hDEADBEEF, 32'h01234567, 0, 0, 32'hDEADBEEF ^ 32'h01234567);
      check("t1_chain", chain64, 64'hDEADBEEF01234567);
      check("t1_shifts", se_cnt64, 64'd64);
      check("t1_busy_cycles", busy_cnt64, 64'd66 + CRC_CYC);
      check("t1_done", done64, 64'd1);
      check("t1_busy", busy64, 64'd0);
      check("t1_in_ready", bus64.in_ready, 64'd0);
      check("t1_error", err64, 64'd0);
      repeat (3) @(negedge clk);
      check("t1_done_held", done64, 64'd1);

      // Test 2: 40-bit chain, low 24 bits of second word never shifted
      run_load(1'b1, 32'hA5A5A5A5, 32'hFF000000, 0, 0, 32'hA5A5A5A5 ^ 32'hFF000000);
      check("t2_chain", chain40, 64'hA5A5A5A5FF);
      check("t2_shifts", se_cnt40, 64'd40);
      check("t2_busy_cycles", busy_cnt40, 64'd42 + CRC_CYC);
      check("t2_done", done40, 64'd1);
      check("t2_error", err40, 64'd0);

      // Test 3: random in_valid gaps
      g0 = int'($urandom_range(7));
      g1 = int'($urandom_range(7));
      run_load(1'b0, 32'hDEADBEEF, 32'h01234567, g0, g1, 32'hDEADBEEF ^ 32'h01234567);
      check("t3_chain", chain64, 64'hDEADBEEF01234567);
      check("t3_shifts", se_cnt64, 64'd64);
      check("t3_busy_cycles", busy_cnt64, 64'(66 + CRC_CYC + g0 + g1));

      // Test 4: reset on the 20th shift cycle, then a clean reload
      pulse_start(1'b0);
      send_word(1'b0, 32'hDEADBEEF, 0);
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (se64 && se_cnt64 == 19) begin
               hit = 1'b1;
               break;
            end
         end
         check("t4_reach_shift20", hit, 64'd1);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t4_busy", busy64, 64'd0);
      check("t4_shift_enable", se64, 64'd0);
      check("t4_in_ready", bus64.in_ready, 64'd0);
      check("t4_done", done64, 64'd0);
      check("t4_shift_data", sd64, 64'd0);
      run_load(1'b0, 32'hDEADBEEF, 32'h01234567, 0, 0, 32'hDEADBEEF ^ 32'h01234567);
      check("t4_chain", chain64, 64'hDEADBEEF01234567);
      check("t4_shifts", se_cnt64, 64'd64);

      // Test 5: start ignored while busy; restart from DONE clears done and reloads zeros
      pulse_start(1'b0);
      send_word(1'b0, 32'hDEADBEEF, 0);
      repeat (5) @(negedge clk);
      start64 = 1'b1;
      @(posedge clk);
      #1 start64 = 1'b0;
      @(negedge clk);
      check("t5_busy_on_start", busy64, 64'd1);
      check("t5_shift_on_start", se64, 64'd1);
      send_word(1'b0, 32'h01234567, 0);
`ifdef CONFIG_CRC_EN
      send_word(1'b0, 32'hDEADBEEF ^ 32'h01234567, 0);
`endif
      wait_done(1'b0);
      check("t5_chain_a", chain64, 64'hDEADBEEF01234567);
      check("t5_shifts_a", se_cnt64, 64'd64);
      pulse_start(1'b0);
      @(negedge clk);
      check("t5_done_cleared", done64, 64'd0);
      check("t5_busy_restart", busy64, 64'd1);
      check("t5_ready_restart", bus64.in_ready, 64'd1);
      send_word(1'b0, 32'h0, 0);
      send_word(1'b0, 32'h0, 0);
`ifdef CONFIG_CRC_EN
      send_word(1'b0, 32'h0, 0);
`endif
      wait_done(1'b0);
      check("t5_chain_b", chain64, 64'h0);
      check("t5_shifts_b", se_cnt64, 64'd64);
      check("t5_done_b", done64, 64'd1);

`ifdef CONFIG_CRC_EN
      // Test 6: check word matching and mismatching
      run_load(1'b0, 32'hDEADBEEF, 32'h01234567, 0, 0, 32'hDEADBEEF ^ 32'h01234567);
      check("t6_good_error", err64, 64'd0);
      check("t6_good_done", done64, 64'd1);
      run_load(1'b0, 32'hDEADBEEF, 32'h01234567, 0, 0, 32'h0);
      check("t6_bad_error", err64, 64'd1);
      check("t6_bad_done", done64, 64'd1);
      check("t6_bad_chain", chain64, 64'hDEADBEEF01234567);
      pulse_start(1'b0);
      @(negedge clk);
      check("t6_error_cleared", err64, 64'd0);
      send_word(1'b0, 32'h0, 0);
      send_word(1'b0, 32'h0, 0);
      send_word(1'b0, 32'h0, 0);
      wait_done(1'b0);
      check("t6_zero_error", err64, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
